// File: rtl/fft_in_loader.sv
// Input sample loader for the 8-point radix-2 FFT.
// Buffers one frame of eight real samples, then issues the four stage-I
// operand pairs (x0,x4), (x2,x6), (x1,x5), (x3,x7) with a butterfly enable.
module fft_in_loader #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          hold,
  output logic [DW-1:0] x_0_re,
  output logic [DW-1:0] x_1_re,
  output logic          bf_en,
  output logic          frame_last
);

  // Frame length is tied to the fixed pairing below.
  localparam int unsigned N  = 8;
  localparam int unsigned WW = $clog2(N);
  localparam int unsigned RW = $clog2(N / 2);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [WW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RW-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW-1:0] x0_q, x0_d;
  logic [DW-1:0] x1_q, x1_d;
  logic          bf_en_q, bf_en_d;
  logic          last_q, last_d;
  logic          wr_en_c;
  logic [DW-1:0] samp_q [N];

  // Ready comes straight from the state register, no input-to-output path.
  assign s_ready    = (state_q == FILL);
  assign x_0_re     = x0_q;
  assign x_1_re     = x1_q;
  assign bf_en      = bf_en_q;
  assign frame_last = last_q;

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      bf_en_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      bf_en_q  <= bf_en_d;
      last_q   <= last_d;
    end
  end

  // Sample buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      samp_q[wr_cnt_q] <= s_data;
    end
  end

  // Next-state, buffer write enable and pair selection.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    bf_en_d  = 1'b0;
    last_d   = 1'b0;
    wr_en_c  = 1'b0;

    case (state_q)
      FILL: begin
        if (s_valid) begin
          wr_en_c  = 1'b1;
          wr_cnt_d = wr_cnt_q + WW'(1);
          if (wr_cnt_q == WW'(N - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!hold) begin
          bf_en_d  = 1'b1;
          last_d   = (rd_cnt_q == RW'(N / 2 - 1));
          rd_cnt_d = rd_cnt_q + RW'(1);
          case (rd_cnt_q)
            2'd0:    begin x0_d = samp_q[0]; x1_d = samp_q[4]; end
            2'd1:    begin x0_d = samp_q[2]; x1_d = samp_q[6]; end
            2'd2:    begin x0_d = samp_q[1]; x1_d = samp_q[5]; end
            default: begin x0_d = samp_q[3]; x1_d = samp_q[7]; end
          endcase
          if (rd_cnt_q == RW'(N / 2 - 1)) begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_fft_in_loader.sv
// Directed bench for fft_in_loader: frames, source gaps, hold, back-to-back
// frames, ignored writes during drain and reset in mid-fill / mid-drain.
module tb_fft_in_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        hold;
  logic [15:0] x_0_re;
  logic [15:0] x_1_re;
  logic        bf_en;
  logic        frame_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int e_a, e_b;

  logic [15:0] fr [8];
  int m0 [4] = '{0, 2, 1, 3};
  int m1 [4] = '{4, 6, 5, 7};

  fft_in_loader #(.DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .hold       (hold),
    .x_0_re     (x_0_re),
    .x_1_re     (x_1_re),
    .bf_en      (bf_en),
    .frame_last (frame_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed fr[0..7]; optional idle cycle before every sample.
  task automatic fill(input bit gaps, output int e_cyc);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = 16'h5555;
        step();
        chk("gap_no_en", 16'(bf_en), 16'd0);
        chk("gap_ready", 16'(s_ready), 16'd1);
      end
      s_valid = 1'b1;
      s_data  = fr[i];
      step();
      chk("fill_no_en", 16'(bf_en), 16'd0);
      chk("fill_ready", 16'(s_ready), 16'(i < 7));
    end
    e_cyc = cyc;
  endtask

  // Expect the four pairs; optional 2-cycle hold after pair hold_after.
  task automatic drain(input bit keep_valid, input int hold_after);
    s_valid = keep_valid;
    s_data  = 16'hDEAD;
    hold    = 1'b0;
    for (int p = 0; p < 4; p++) begin
      step();
      chk("pair_en", 16'(bf_en), 16'd1);
      chk("pair_last", 16'(frame_last), 16'(p == 3));
      chk("pair_x0", x_0_re, fr[m0[p]]);
      chk("pair_x1", x_1_re, fr[m1[p]]);
      chk("drain_ready", 16'(s_ready), 16'(p == 3));
      if (p == hold_after) begin
        hold = 1'b1;
        repeat (2) begin
          step();
          chk("hold_en", 16'(bf_en), 16'd0);
          chk("hold_last", 16'(frame_last), 16'd0);
          chk("hold_x0", x_0_re, fr[m0[p]]);
          chk("hold_x1", x_1_re, fr[m1[p]]);
          chk("hold_ready", 16'(s_ready), 16'd0);
        end
        hold = 1'b0;
      end
    end
  endtask

  task automatic idle_check();
    s_valid = 1'b0;
    step();
    chk("post_en", 16'(bf_en), 16'd0);
    chk("post_ready", 16'(s_ready), 16'd1);
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    hold    = 1'b0;
    step();
    step();
    chk("rst_ready", 16'(s_ready), 16'd1);
    chk("rst_en", 16'(bf_en), 16'd0);
    chk("rst_last", 16'(frame_last), 16'd0);
    chk("rst_x0", x_0_re, 16'd0);
    chk("rst_x1", x_1_re, 16'd0);
    reset = 1'b0;
    step();

    // Basic frame 1..8
    for (int i = 0; i < 8; i++) fr[i] = 16'(i + 1);
    fill(1'b0, e_a);
    drain(1'b0, -1);
    idle_check();

    // Source gaps, with hold high during fill (ignored)
    for (int i = 0; i < 8; i++) fr[i] = 16'(i + 1);
    hold = 1'b1;
    fill(1'b1, e_a);
    drain(1'b0, -1);
    idle_check();

    // Hold for two cycles after pair (3,7)
    fill(1'b0, e_a);
    drain(1'b0, 1);
    idle_check();

    // Back-to-back: A = -1..-8, B = 7FFF,8000,0..; DEAD offered in drain
    for (int i = 0; i < 8; i++) fr[i] = 16'(-(i + 1));
    fill(1'b0, e_a);
    drain(1'b1, -1);
    fr[0] = 16'h7FFF; fr[1] = 16'h8000;
    for (int i = 2; i < 8; i++) fr[i] = 16'h0000;
    fill(1'b0, e_b);
    chk("frame_period", 16'(e_b - e_a), 16'd12);
    s_valid = 1'b0;
    step();
    chk("b_first_x0", x_0_re, 16'h7FFF);
    chk("b_first_x1", x_1_re, 16'h0000);
    step();
    step();
    chk("b_third_x0", x_0_re, 16'h8000);
    chk("b_third_x1", x_1_re, 16'h0000);
    step();
    chk("b_last", 16'(frame_last), 16'd1);
    idle_check();

    // Reset after 5 samples of a junk frame
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h1110 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    reset   = 1'b1;
    #1;
    chk("rst5_ready", 16'(s_ready), 16'd1);
    chk("rst5_en", 16'(bf_en), 16'd0);
    chk("rst5_x0", x_0_re, 16'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) fr[i] = 16'h0A00 + 16'(i);
    fill(1'b0, e_a);
    drain(1'b0, -1);
    idle_check();

    // Reset right after pair 1 has issued
    for (int i = 0; i < 8; i++) fr[i] = 16'h0B10 + 16'(i);
    fill(1'b0, e_a);
    s_valid = 1'b0;
    step();
    step();
    chk("mid_x0", x_0_re, 16'h0B12);
    reset = 1'b1;
    #1;
    chk("rstd_ready", 16'(s_ready), 16'd1);
    chk("rstd_en", 16'(bf_en), 16'd0);
    chk("rstd_last", 16'(frame_last), 16'd0);
    chk("rstd_x0", x_0_re, 16'd0);
    chk("rstd_x1", x_1_re, 16'd0);
    step();
    reset = 1'b0;
    step();
    chk("rstd_idle_en", 16'(bf_en), 16'd0);
    for (int i = 0; i < 8; i++) fr[i] = 16'h0C20 + 16'(i);
    fill(1'b0, e_a);
    drain(1'b0, -1);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
